txlkup_sched: RTL and testbench

- Shares the routing table's single destination-lookup port (TX_VALID/TX_ACK/TX_DSTMAC/TX_PORT) among NREQ transmit-side requesters, e.g. one per egress packet builder.
- Round-robin arbitration, one lookup in flight at a time.
- Each lookup result returns to its requester with a one-cycle acknowledge.
- Sits between the per-port TX header parsers and the routing table.

---
 rtl/txlkup_sched.sv | 149 ++++++++++++++
 tb/tb_txlkup_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/txlkup_sched.sv
// rtl/txlkup_sched.sv - round-robin sharing of the routing table TX lookup port; optional lookup watchdog via TXLKUP_TIMEOUT_EN
module txlkup_sched #(
  parameter int              NREQ         = 4,
  parameter int              NETH         = 4,
  parameter int              MACW         = 48,
  parameter logic [NETH-1:0] DEFAULT_PORT = {NETH{1'b1}},
  parameter int              LGTIMEOUT    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*MACW-1:0] i_req_dstmac,
  output logic [NREQ-1:0]      o_req_ack,
  output logic [NETH-1:0]      o_req_port,
  output logic                 o_tbl_valid,
  output logic [MACW-1:0]      o_tbl_dstmac,
  input  logic                 i_tbl_ack,
  input  logic [NETH-1:0]      i_tbl_port,
`ifdef TXLKUP_TIMEOUT_EN
  output logic                 o_tbl_timeout,
`endif
  output logic                 o_busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

  state_t          state, next_state;
  logic [GW-1:0]   rr;          // requester that gets first look at the next grant
  logic [GW-1:0]   gnt;         // requester owning the lookup in flight
  logic [GW-1:0]   pick;
  logic [GW-1:0]   idx_g;
  logic            pick_found;
  int              idx;
  logic [NETH-1:0] result;
  logic            dropped;     // owner let go of its request; finish silently
  logic            tmo_hit;
  logic            tbl_done;

`ifdef TXLKUP_TIMEOUT_EN
  // The count starts at 0 on the first LOOKUP edge, so the edge that would
  // bring it to all-ones is the last LOOKUP cycle the table is allowed.
  localparam logic [LGTIMEOUT-1:0] TMO_LAST = LGTIMEOUT'((1 << LGTIMEOUT) - 2);
  logic [LGTIMEOUT-1:0] tmo_cnt;
  assign tmo_hit = (state == LOOKUP) && !i_tbl_ack && (tmo_cnt == TMO_LAST);
`else
  logic unused_cfg;
  assign unused_cfg = ^{DEFAULT_PORT, LGTIMEOUT};
  assign tmo_hit    = 1'b0;
`endif

  assign tbl_done = (state == LOOKUP) && (i_tbl_ack || tmo_hit);

  // Round-robin pick: lowest offset from rr wins, so scan offsets downwards.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    idx        = 0;
    idx_g      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = int'(rr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_g = GW'(idx);
      if (i_req_valid[idx_g]) begin
        pick       = idx_g;
        pick_found = 1'b1;
      end
    end
  end

  // Next-state logic for IDLE -> LOOKUP -> RESP -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = LOOKUP;
      LOOKUP:  if (tbl_done) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= next_state;
  end

  // Registered datapath: table request, result capture and requester acknowledge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rr            <= '0;
      gnt           <= '0;
      result        <= '0;
      dropped       <= 1'b0;
      o_req_ack     <= '0;
      o_req_port    <= '0;
      o_tbl_valid   <= 1'b0;
      o_tbl_dstmac  <= '0;
      o_busy        <= 1'b0;
`ifdef TXLKUP_TIMEOUT_EN
      tmo_cnt       <= '0;
      o_tbl_timeout <= 1'b0;
`endif
    end else begin
      o_req_ack  <= '0;
      o_req_port <= '0;
      o_busy     <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt          <= pick;
            o_tbl_dstmac <= i_req_dstmac[int'(pick)*MACW +: MACW];
            o_tbl_valid  <= 1'b1;
            dropped      <= 1'b0;
`ifdef TXLKUP_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
          end
        end
        LOOKUP: begin
          if (!i_req_valid[gnt]) dropped <= 1'b1;
          if (i_tbl_ack) begin
            o_tbl_valid <= 1'b0;
            result      <= i_tbl_port;
          end
`ifdef TXLKUP_TIMEOUT_EN
          else if (tmo_hit) begin
            o_tbl_valid   <= 1'b0;
            result        <= DEFAULT_PORT;
            o_tbl_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (i_req_valid[gnt] && !dropped) begin
            o_req_ack[gnt] <= 1'b1;
            o_req_port     <= result;
          end
          rr <= (gnt == GW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_txlkup_sched.sv
// tb/tb_txlkup_sched.sv - randomized and directed checks of txlkup_sched against a transaction-level model
module tb_txlkup_sched;
  localparam int NREQ = 4;
  localparam int NETH = 4;
  localparam int MACW = 48;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*MACW-1:0] req_dstmac;
  logic [NREQ-1:0]      req_ack;
  logic [NETH-1:0]      req_port;
  logic                 tbl_valid;
  logic [MACW-1:0]      tbl_dstmac;
  logic                 tbl_ack;
  logic [NETH-1:0]      tbl_port;
  logic                 busy;
`ifdef TXLKUP_TIMEOUT_EN
  logic                 tbl_timeout;
`endif

  txlkup_sched dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_req_valid  (req_valid),
    .i_req_dstmac (req_dstmac),
    .o_req_ack    (req_ack),
    .o_req_port   (req_port),
    .o_tbl_valid  (tbl_valid),
    .o_tbl_dstmac (tbl_dstmac),
    .i_tbl_ack    (tbl_ack),
    .i_tbl_port   (tbl_port),
`ifdef TXLKUP_TIMEOUT_EN
    .o_tbl_timeout(tbl_timeout),
`endif
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cycle   = 0;

  // transaction-level model of the arbiter
  int              m_rr;
  int              m_g;
  int              m_age;
  bit              m_active;
  bit              m_dropped;
  bit              m_timeout;
  logic [MACW-1:0] m_mac;
  logic [NETH-1:0] m_port;

  // bench-side table and requester behaviour
  int              tbl_delay;
  bit              tbl_fixed_en;
  logic [NETH-1:0] tbl_fixed;
  bit              stray_en;
  bit              auto_raise;
  int              raise_pct;
  logic [NREQ-1:0] applied;
  int              acks[$];
  int              ack_cycles[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [NETH-1:0] resp_for(input logic [MACW-1:0] mac);
    if (tbl_fixed_en) return tbl_fixed;
    return mac[3:0] ^ mac[11:8] ^ 4'h9;
  endfunction

  task automatic set_mac(input int k, input logic [MACW-1:0] mac);
    req_dstmac[k*MACW +: MACW] = mac;
  endtask

  task automatic rand_mac(input int k);
    logic [63:0] r;
    r = {$urandom, $urandom};
    set_mac(k, r[MACW-1:0]);
  endtask

  // One clock: apply inputs at the edge, check outputs at the following negedge,
  // then play table and requesters for the next edge.
  task automatic tick();
    logic [NREQ-1:0] ack_exp;
    logic [NETH-1:0] port_exp;
    int              d_eff;
    bit              to;
    applied = req_valid;
    @(negedge clk);
    cycle++;
    tbl_ack = 1'b0;
    if (auto_raise) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid[k] && ($urandom_range(99) < raise_pct)) begin
          rand_mac(k);
          req_valid[k] = 1'b1;
        end
      end
    end
    d_eff = tbl_delay;
    to    = 1'b0;
`ifdef TXLKUP_TIMEOUT_EN
    if (tbl_delay > 14) begin
      d_eff = 14;
      to    = 1'b1;
    end
`endif
    if (m_active && !applied[m_g]) m_dropped = 1'b1;
    if (m_active) begin
      m_age++;
      ack_exp  = '0;
      port_exp = '0;
      if (m_age == d_eff + 3 && !m_dropped) begin
        ack_exp[m_g] = 1'b1;
        port_exp     = m_port;
      end
      if (to && m_age == d_eff + 2) m_timeout = 1'b1;
      chk("req_ack", req_ack, ack_exp);
      chk("req_port", req_port, port_exp);
      chk("tbl_valid", tbl_valid, m_age <= d_eff + 1);
      chk("busy", busy, m_age < d_eff + 3);
      if (m_age <= d_eff + 1) chk("tbl_dstmac_hold", tbl_dstmac, m_mac);
      if (m_age == d_eff + 1) begin
        if (!to) begin
          tbl_ack  = 1'b1;
          tbl_port = resp_for(m_mac);
          m_port   = tbl_port;
        end else begin
          m_port = '1;
        end
      end
      if (m_age == d_eff + 3) begin
        m_active = 1'b0;
        m_rr     = (m_g + 1) % NREQ;
        if (!m_dropped) begin
          acks.push_back(m_g);
          ack_cycles.push_back(cycle);
          req_valid[m_g] = 1'b0;
        end
      end
    end else begin
      chk("req_ack_idle", req_ack, '0);
      if (applied != '0) begin
        m_g = -1;
        for (int i = 0; i < NREQ; i++) begin
          if (m_g < 0 && applied[(m_rr + i) % NREQ]) m_g = (m_rr + i) % NREQ;
        end
        m_active  = 1'b1;
        m_age     = 1;
        m_dropped = 1'b0;
        m_mac     = req_dstmac[m_g*MACW +: MACW];
        chk("tbl_valid_start", tbl_valid, 1'b1);
        chk("tbl_dstmac_grant", tbl_dstmac, m_mac);
        chk("busy_start", busy, 1'b1);
      end else begin
        chk("tbl_valid_idle", tbl_valid, 1'b0);
        chk("busy_idle", busy, 1'b0);
      end
    end
`ifdef TXLKUP_TIMEOUT_EN
    chk("tbl_timeout", tbl_timeout, m_timeout);
`endif
    if (stray_en && !(m_active && m_age <= d_eff + 1) && $urandom_range(3) == 0) begin
      tbl_ack  = 1'b1;
      tbl_port = NETH'($urandom);
    end
  endtask

  task automatic run_until_acks(input int n, input int budget);
    int s;
    s = acks.size();
    for (int i = 0; i < budget && acks.size() < s + n; i++) tick();
    chk("ack_budget", acks.size() - s, n);
  endtask

  // Async reset at an arbitrary point mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tbl_valid", tbl_valid, 1'b0);
    chk("rst_req_ack", req_ack, '0);
    chk("rst_req_port", req_port, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tbl_dstmac", tbl_dstmac, '0);
    m_rr      = 0;
    m_active  = 1'b0;
    m_timeout = 1'b0;
    tbl_ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s;
    rst_n        = 1'b1;
    req_valid    = '0;
    req_dstmac   = '0;
    tbl_ack      = 1'b0;
    tbl_port     = '0;
    tbl_delay    = 1;
    tbl_fixed_en = 1'b0;
    tbl_fixed    = '0;
    stray_en     = 1'b0;
    auto_raise   = 1'b0;
    raise_pct    = 0;
    m_rr         = 0;
    m_active     = 1'b0;
    m_timeout    = 1'b0;
    @(negedge clk);
    do_reset();

    // single request from requester 1 against an ideal table
    tbl_fixed_en = 1'b1;
    tbl_fixed    = 4'b0100;
    set_mac(1, 48'h0200_0000_0001);
    req_valid = 4'b0010;
    s = cycle;
    run_until_acks(1, 20);
    chk("single_who", acks[$], 1);
    chk("single_latency", ack_cycles[$] - (s + 1), 3);
    tbl_fixed_en = 1'b0;
    repeat (3) tick();

    // all four requesting continuously from reset
    do_reset();
    for (int k = 0; k < NREQ; k++) rand_mac(k);
    req_valid  = '1;
    auto_raise = 1'b1;
    raise_pct  = 100;
    s = acks.size();
    run_until_acks(5, 40);
    for (int j = 0; j < 5; j++) chk("rr_order", acks[s + j], j % NREQ);
    for (int j = 1; j < 5; j++) chk("rr_spacing", ack_cycles[s + j] - ack_cycles[s + j - 1], 4);
    auto_raise = 1'b0;
    req_valid  = '0;
    repeat (8) tick();

    // slow table
    tbl_delay = 6;
    rand_mac(3);
    req_valid[3] = 1'b1;
    s = acks.size();
    repeat (16) tick();
    chk("slow_ack_count", acks.size() - s, 1);
    chk("slow_who", acks[$], 3);
    tbl_delay = 2;

    // requester 2 abandons its lookup; requester 3 is served next
    do_reset();
    rand_mac(2);
    rand_mac(3);
    req_valid = 4'b1100;
    tick();
    tick();
    req_valid[2] = 1'b0;
    s = acks.size();
    run_until_acks(1, 30);
    chk("drop_next_grant", acks[s], 3);
    repeat (3) tick();

    // reset in the middle of a lookup, then requester 0 goes first
    tbl_delay = 4;
    req_valid = 4'b0010;
    tick();
    tick();
    req_valid = 4'b1111;
    tick();
    do_reset();
    s = acks.size();
    run_until_acks(1, 30);
    chk("post_reset_first", acks[s], 0);
    req_valid = '0;
    repeat (8) tick();

`ifdef TXLKUP_TIMEOUT_EN
    // table never answers; watchdog supplies the default port
    tbl_delay = 1000;
    rand_mac(0);
    req_valid[0] = 1'b1;
    s = acks.size();
    repeat (25) tick();
    chk("timeout_ack_count", acks.size() - s, 1);
    stray_en = 1'b1;
    repeat (10) tick();
    stray_en = 1'b0;
`endif

    // randomized traffic with varying table delay and stray table acks
    tbl_delay  = 1;
    stray_en   = 1'b1;
    auto_raise = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!m_active && $urandom_range(7) == 0) tbl_delay = $urandom_range(5, 1);
      if ($urandom_range(31) == 0) raise_pct = $urandom_range(100);
      tick();
    end
    auto_raise = 1'b0;
    stray_en   = 1'b0;
    req_valid  = '0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
